// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start/data/stop recovery, framing and overrun flags, valid/ack word interface
// Optional two-flop input synchronizer on rx when UART_RX_SYNC_EN is defined.
module uart_rx #(
  parameter int D_WIDTH      = 13,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rx_ack,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               rx_ferr,
  output logic               rx_ovr
);

  localparam int H   = (CLKS_PER_BIT - 1) / 2;
  localparam int BCW = $clog2(D_WIDTH + 1);
  localparam int CCW = ($clog2(CLKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);

  // Cycle-counter values at which a bit is sampled / the start bit is re-checked.
  localparam logic [CCW-1:0] CNT_BIT   = CCW'(CLKS_PER_BIT - 1);
  localparam logic [CCW-1:0] CNT_MID   = CCW'((H > 0) ? (H - 1) : 0);
  localparam logic [BCW-1:0] BITS_LAST = BCW'(D_WIDTH - 1);

  typedef enum logic [2:0] {
    HUNT,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic               s;
  state_t             state_q, state_d;
  logic [CCW-1:0]     cnt_q, cnt_d;
  logic [BCW-1:0]     bit_q, bit_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic [D_WIDTH-1:0] data_d;
  logic               valid_d, busy_d, ferr_d, ovr_d;
  logic               land;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign s = sync_q[1];
`else
  assign s = rx;
`endif

  // State, counters, shift register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_busy  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rx_data  <= data_d;
      rx_valid <= valid_d;
      rx_busy  <= busy_d;
      rx_ferr  <= ferr_d;
      rx_ovr   <= ovr_d;
    end
  end

  // Next-state, bit sampling and valid/ack handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    land    = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      HUNT: begin
        if (s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!s) begin
          cnt_d   = '0;
          bit_d   = '0;
          // With H==0 the detection edge is already the mid-bit sample.
          state_d = (H == 0) ? DATA : START;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          shift_d = {s, shift_q[D_WIDTH-1:1]};
          if (bit_q == BITS_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = '0;
          if (s) begin
            land    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = HUNT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    data_d  = rx_data;
    valid_d = rx_valid;
    ovr_d   = 1'b0;
    if (land) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = rx_valid && !rx_ack;
    end else if (rx_ack) begin
      valid_d = 1'b0;
    end

    // Busy rises one edge after start detection and drops on the edge the frame ends.
    busy_d = (state_q inside {START, DATA, STOP}) && (state_d inside {START, DATA, STOP});
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at CLKS_PER_BIT 1 and 8
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx1 = 1'b1, ack1 = 1'b0, rx8 = 1'b1, ack8 = 1'b0;
  logic [12:0] d1, d8;
  logic        v1, b1, f1, o1, v8, b8, f8, o8;

  uart_rx #(.D_WIDTH(13), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .rx_ack(ack1),
    .rx_data(d1), .rx_valid(v1), .rx_busy(b1), .rx_ferr(f1), .rx_ovr(o1)
  );

  uart_rx #(.D_WIDTH(13), .CLKS_PER_BIT(8)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_ack(ack8),
    .rx_data(d8), .rx_valid(v8), .rx_busy(b8), .rx_ferr(f8), .rx_ovr(o8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [12:0] data;
    logic        valid;
    logic        ferr;
    logic        ovr;
    int          cyc;
  } ev_t;

  ev_t q1[$];
  ev_t q8[$];
  logic [12:0] pd[2];
  logic        pv[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int sel, input logic [12:0] d, input logic v, input logic f, input logic o);
    ev_t   e;
    string tag = (sel != 0) ? "dut8" : "dut1";
    if (f || o || (v && !pv[sel]) || (d != pd[sel])) begin
      if (((sel != 0) ? q8.size() : q1.size()) == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_unexpected_event: data %0h valid %0b ferr %0b ovr %0b, expected no event",
                 tag, d, v, f, o);
      end else begin
        e = (sel != 0) ? q8.pop_front() : q1.pop_front();
        check({tag, "_data"},  32'(d), 32'(e.data));
        check({tag, "_valid"}, 32'(v), 32'(e.valid));
        check({tag, "_ferr"},  32'(f), 32'(e.ferr));
        check({tag, "_ovr"},   32'(o), 32'(e.ovr));
        check({tag, "_edge"},  32'(cyc), 32'(e.cyc));
      end
    end
    pd[sel] = d;
    pv[sel] = v;
  endtask

  // Monitor: any output event pops the oldest expectation for that DUT.
  always @(negedge clk) begin
    if (rst) begin
      pd[0] = '0; pv[0] = 1'b0; pd[1] = '0; pv[1] = 1'b0;
    end else begin
      mon(0, d1, v1, f1, o1);
      mon(1, d8, v8, f8, o8);
    end
  end

  task automatic set_rx(input int sel, input logic val);
    if (sel != 0) rx8 = val;
    else rx1 = val;
  endtask

  task automatic pulse_ack(input int sel);
    if (sel != 0) ack8 = 1'b1;
    else ack1 = 1'b1;
    @(negedge clk);
    if (sel != 0) ack8 = 1'b0;
    else ack1 = 1'b0;
  endtask

  // Called on a falling edge; the next rising edge is the start-detection edge.
  task automatic send_frame(input int sel, input logic [12:0] d, input logic stop, input logic ack_land,
                            input logic [12:0] ed, input logic ev, input logic ef, input logic eo);
    int  cpb = (sel != 0) ? 8 : 1;
    int  h   = (sel != 0) ? 3 : 0;
    ev_t e;
    e.data  = ed;
    e.valid = ev;
    e.ferr  = ef;
    e.ovr   = eo;
    e.cyc   = cyc + 1 + h + 14 * cpb;
    if (sel != 0) q8.push_back(e);
    else q1.push_back(e);
    set_rx(sel, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      set_rx(sel, d[i]);
      repeat (cpb) @(negedge clk);
    end
    set_rx(sel, stop);
    if (ack_land) ack1 = 1'b1;
    repeat (cpb) @(negedge clk);
    if (ack_land) ack1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [12:0] partial;

  initial begin
    @(negedge clk);
    check("reset_data",  32'(d1), 32'h0);
    check("reset_valid", 32'(v1), 32'h0);
    check("reset_busy",  32'(b1), 32'h0);
    check("reset_ferr",  32'(f1), 32'h0);
    check("reset_ovr",   32'(o1), 32'h0);
    check("reset_valid8", 32'(v8), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame, then acknowledge.
    send_frame(0, 13'h1A5B, 1'b1, 1'b0, 13'h1A5B, 1'b1, 1'b0, 1'b0);
    pulse_ack(0);
    check("ack_clears_valid_a", 32'(v1), 32'h0);

    // Back-to-back frames, each acknowledged.
    send_frame(0, 13'h0001, 1'b1, 1'b0, 13'h0001, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(0, 13'h1FFF, 1'b1, 1'b0, 13'h1FFF, 1'b1, 1'b0, 1'b0);
      pulse_ack(0);
    join
    pulse_ack(0);
    check("ack_clears_valid_b", 32'(v1), 32'h0);

    // Overrun: second word lands unacknowledged.
    send_frame(0, 13'h1555, 1'b1, 1'b0, 13'h1555, 1'b1, 1'b0, 1'b0);
    send_frame(0, 13'h0AAA, 1'b1, 1'b0, 13'h0AAA, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("ovr_one_cycle",  32'(o1), 32'h0);
    check("ovr_valid_kept", 32'(v1), 32'h1);
    // Ack on the landing edge suppresses overrun.
    send_frame(0, 13'h0123, 1'b1, 1'b1, 13'h0123, 1'b1, 1'b0, 1'b0);
    pulse_ack(0);
    check("ack_clears_valid_c", 32'(v1), 32'h0);

    // Framing error, then line held low: no restart until it returns high.
    send_frame(0, 13'h00F0, 1'b0, 1'b0, 13'h0123, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ferr_hold_busy", 32'(b1), 32'h0);
    end
    check("ferr_one_cycle", 32'(f1), 32'h0);
    rx1 = 1'b1;
    @(negedge clk);
    send_frame(0, 13'h0C3C, 1'b1, 1'b0, 13'h0C3C, 1'b1, 1'b0, 1'b0);

    // CLKS_PER_BIT=8: 3-cycle glitch rejected at the mid-bit check.
    rx8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("glitch_busy_rise", 32'(b8), 32'h1);
    @(negedge clk);
    rx8 = 1'b1;
    @(negedge clk);
    check("glitch_busy_fall", 32'(b8), 32'h0);
    repeat (4) @(negedge clk);
    check("glitch_busy_idle", 32'(b8), 32'h0);
    send_frame(1, 13'h1234, 1'b1, 1'b0, 13'h1234, 1'b1, 1'b0, 1'b0);

    // Reset during data bit 6.
    partial = 13'h0F0F;
    rx1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rx1 = partial[i];
      @(negedge clk);
    end
    rx1 = partial[6];
    check("pre_reset_busy", 32'(b1), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_reset_data",   32'(d1), 32'h0);
    check("mid_reset_valid",  32'(v1), 32'h0);
    check("mid_reset_busy",   32'(b1), 32'h0);
    check("mid_reset_ferr",   32'(f1), 32'h0);
    check("mid_reset_ovr",    32'(o1), 32'h0);
    check("mid_reset_data8",  32'(d8), 32'h0);
    check("mid_reset_valid8", 32'(v8), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rx1 = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    send_frame(0, 13'h0F0F, 1'b1, 1'b0, 13'h0F0F, 1'b1, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    check("dut1_queue_empty", 32'(q1.size()), 32'h0);
    check("dut8_queue_empty", 32'(q8.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side UART for the one-clock-domain serial link driven by the team's transmitter. Recovers frames of the form idle-high, one low start bit, D_WIDTH data bits LSB first, one high stop bit, and presents each word on a parallel valid/ack interface. Checks framing and flags overrun. Sits between the serial pin (or the transmitter's `tx` in loopback) and the consuming logic.

## Interface
- `D_WIDTH`, 13, data bits per frame.
- `CLKS_PER_BIT`, 1, clock cycles per serial bit. Must be ≥1. The transmitter runs at 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, idle high.
- `rx_ack`  in  1  consumer has taken `rx_data`; clears `rx_valid`.
- `rx_data`  out  D_WIDTH  last good received word.
- `rx_valid`  out  1  `rx_data` holds an unacknowledged word.
- `rx_busy`  out  1  high while in START, DATA or STOP.
- `rx_ferr`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_ovr`  out  1  one-cycle pulse: word landed while the previous one was unacknowledged.

## Operation
- Internal sample `s` is `rx`, or the synchronizer output when `UART_RX_SYNC_EN` is defined.
- Mid-bit offset: H = (CLKS_PER_BIT-1)/2 (integer division). Bit counter is ceil(log2(D_WIDTH+1)) bits wide. Cycle counter is ceil(log2(CLKS_PER_BIT+1)) bits wide, minimum 1.
- **HUNT** (reset state): wait for `s`==1, then go to IDLE.
- **IDLE**: on `s`==0, go to START with cycle count = 0. If H==0, go straight to DATA; that detection edge counts as the start-bit sample.
- **START**: the cycle counter increments each edge. When it reaches H, re-check `s`.
  - `s`==0: start confirmed; go to DATA, counter = 0.
  - `s`==1: glitch; return to IDLE with no flags.
- **DATA**: sample `s` every CLKS_PER_BIT edges into a shift register, LSB first. After D_WIDTH samples, go to STOP.
- **STOP**: sample `s` CLKS_PER_BIT edges after the last data bit.
  - `s`==1: load `rx_data`, set `rx_valid`, go to IDLE.
  - `s`==0: pulse `rx_ferr`, leave `rx_data` and `rx_valid` unchanged, go to HUNT.
- Handshake, evaluated on each edge:
  - `rx_ack` && `rx_valid`, with no new word landing: `rx_valid` → 0.
  - New word lands while `rx_valid`==0: `rx_valid` → 1.
  - New word lands while `rx_valid`==1 and `rx_ack`==0: overwrite `rx_data`, keep `rx_valid`=1, pulse `rx_ovr`.
  - New word lands while `rx_valid`==1 and `rx_ack`==1: overwrite `rx_data`, keep `rx_valid`=1, no `rx_ovr`.
  - `rx_ack` while `rx_valid`==0: ignored.
- Back-to-back frames: IDLE accepts a start on the edge right after the stop sample.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `rx_ferr`=0, `rx_ovr`=0. State = HUNT, all counters 0, synchronizer flops = 1.
- Reset asserted mid-frame: abort immediately, discard partial data, no flags. After release, the block must see `s`==1 before accepting a new start.
- Let edge k be the first edge that samples `s`==0 in IDLE.
  - Data bit i (i = 0..D_WIDTH-1) is sampled at edge k+H+(i+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge k+H+(D_WIDTH+1)·CLKS_PER_BIT.
  - `rx_data`/`rx_valid` (or `rx_ferr`) are registered on that stop-sample edge.
- Defaults (CLKS_PER_BIT=1, D_WIDTH=13): `rx_valid` rises 14 edges after start detection.
- `rx_busy` is registered and rises on the edge after k. It falls on the stop-sample edge, or on the edge a glitch is rejected.
- All outputs are registered. There is no combinational path from `rx` or `rx_ack` to any output.

## Configuration
- `UART_RX_SYNC_EN` defined: two-flop synchronizer on `rx`, both flops reset to 1. Every serial sample edge shifts 2 cycles later.
- Not defined: `rx` is sampled directly. This is valid only when the sender shares `clk`.

## Test plan
- Loopback with the transmitter, defaults, 13'h1A5B sent → `rx_data`=13'h1A5B, `rx_valid` high 14 edges after start detection, `rx_ferr`=`rx_ovr`=0.
- Two frames back-to-back, 13'h0001 then 13'h1FFF, `rx_ack` pulsed after each → two `rx_valid` events with correct data and no flags.
- Second frame 13'h0AAA completes with no `rx_ack` → `rx_data`=13'h0AAA, `rx_ovr` one-cycle pulse, `rx_valid` stays 1. Repeat with `rx_ack` on the landing edge → no `rx_ovr`.
- Frame with the stop bit forced low → `rx_ferr` pulse, `rx_data` unchanged. Hold `rx` low 5 more cycles → no new start until `rx` goes high for one cycle.
- CLKS_PER_BIT=8: 3-cycle low glitch on `rx` → rejected at H=3, no `rx_busy` after return to IDLE. Full frame 13'h1234 → received correctly.
- Assert `rst` at data bit 6 of a frame → all outputs 0 immediately. The next full frame 13'h0F0F is received correctly.
